vlc_bit_packer: RTL
===================

# vlc_bit_packer

Packs the variable-length codewords produced by the AC level, AC run and DC entropy-coding stages into a contiguous MSB-first stream of 32-bit words for slice assembly. It sits directly downstream of the entropy coders and consumes their `sum` and `codeword_length` pairs together with their start, valid and end framing. At block end it flushes the partial word, zero-padded, and reports the exact payload bit count.

## Interface
- No parameters. Word width is fixed at 32 bits, codeword length at 0..32 bits, accumulator at 64 bits.
- `clk`  in  1  clock; all state updates on the rising edge. Reset `reset_n`, asynchronous, active-low; clock `clk`.
- `reset_n`  in  1  asynchronous active-low reset.
- `input_start`  in  1  first cycle of a block; may arrive without `input_valid`.
- `input_valid`  in  1  `sum` and `codeword_length` are meaningful this cycle.
- `input_end`  in  1  last cycle of a block; may arrive without `input_valid`.
- `sum`  in  32  codeword value, right-justified; bits at or above `codeword_length` are ignored.
- `codeword_length`  in  32  number of codeword bits, 0..32.
- `output_valid`  out  1  `output_word` is valid this cycle.
- `output_word`  out  32  packed bits, first-arriving bit at bit 31.
- `output_end`  out  1  final cycle of the block's output.
- `output_bit_count`  out  32  payload bits in the block, excluding padding; valid while `output_end`=1.
- `output_word_count`  out  32  words emitted in the block, including the final one; valid while `output_end`=1.
- `error`  out  1  sticky. Set on `codeword_length` > 32, or on `input_start` while ACTIVE. Cleared only by reset.

## Operation
- States:
  - IDLE: no block open.
  - ACTIVE: block open.
  - FLUSH: one cycle that emits the padded remainder.
- Datapath: 64-bit accumulator `acc`, left-aligned. Fill level `fill` is 0..63 and is always < 32 at the start of a cycle.
- On `input_start`, from IDLE or ACTIVE:
  - Clear `acc`, `fill` and both counters, then enter ACTIVE.
  - If the block was already ACTIVE, discard the old contents and set `error`.
  - A codeword arriving in the same cycle belongs to the new block.
- Append: `input_valid` in ACTIVE, or in the start cycle.
  - Length L is `codeword_length`, clamped to 32. A value above 32 also sets `error`.
  - The masked value `sum & ((1<<L)-1)` is written to `acc` starting at bit position 63-`fill`.
  - Update `fill += L` and `bit_count += L`. L=0 is a no-op.
- Emit: if `fill` ≥ 32 after the append:
  - Register `acc[63:32]` as `output_word` with `output_valid`=1.
  - Shift `acc` left by 32, `fill -= 32`, and increment `word_count`.
  - At most one word is emitted per cycle, so no backpressure is needed.
- `input_end`, processed after that cycle's append and emit. Let f be the fill after the emit.
  - If a word was emitted this cycle and f > 0: go to FLUSH. The next cycle emits `{acc[63:32]}` zero-padded, with `output_end`, then returns to IDLE.
  - If no word was emitted and f > 0: emit the padded word in this same registered cycle with `output_end`, then go to IDLE.
  - If f = 0 and a word was emitted: that word carries `output_end`.
  - If f = 0 and no word was emitted: `output_end`=1 with `output_valid`=0 and `output_word`=0.
- Inputs with `input_valid` in IDLE without start are ignored. All inputs are ignored during FLUSH. Upstream guarantees at least one idle cycle after `input_end`.
- Counters wrap modulo 2^32.

## Timing
- All outputs are registered. Latency is 1 cycle from an input cycle to its word or end indication, or 2 cycles via FLUSH.
- `output_valid` and `output_end` are single-cycle pulses. `output_word` is 0 whenever `output_valid`=0.
- Reset values: state IDLE; all outputs 0; `acc`, `fill` and counters 0; `error` 0.
- Reset asserted mid-block discards the block immediately. No `output_end` is produced for it.
- Simultaneous start, valid and end: a single-codeword block, output on the next cycle.

## Test plan
- Basic pack:
  - Stimulus: start+valid (0x5,3); valid (0x1,1); end+valid (0x0,0).
  - Required: one cycle after end, `output_word`=0xB0000000, `output_valid`=1, `output_end`=1, `output_bit_count`=4, `output_word_count`=1.
- Exact word:
  - Stimulus: start+valid (0xDEADBEEF,32).
  - Required: next cycle `output_word`=0xDEADBEEF with `output_end`=0. A following bare end gives `output_end`=1, `output_valid`=0, `output_bit_count`=32.
- Straddle plus flush:
  - Stimulus: start, seven valid (0xA,4), then end+valid (0xFF,8).
  - Required: `output_word`=0xAAAAAAAF, then on the next cycle 0xF0000000 with `output_end`, `output_bit_count`=36, `output_word_count`=2.
- Masking:
  - Stimulus: start+valid (0xFFFFFFFF,3)+end.
  - Required: `output_word`=0xE0000000, `output_bit_count`=3.
- Errors:
  - Stimulus: `codeword_length`=33 with sum 0xFFFFFFFF.
  - Required: `error`=1, length treated as 32.
  - Stimulus: a second start while ACTIVE.
  - Required: `error` stays 1, and the new block's counts start from 0.
- Reset mid-block:
  - Stimulus: assert `reset_n`=0 after 20 bits are appended.
  - Required: all outputs 0 immediately. A subsequent block packs as in the basic scenario.

Source files
------------

// File: rtl/vlc_bit_packer.sv
// Packs right-justified variable-length codewords into an MSB-first stream of
// 32-bit words, flushing a zero-padded tail word and reporting counts at block end.
module vlc_bit_packer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        input_start,
   input  logic        input_valid,
   input  logic        input_end,
   input  logic [31:0] sum,
   input  logic [31:0] codeword_length,
   output logic        output_valid,
   output logic [31:0] output_word,
   output logic        output_end,
   output logic [31:0] output_bit_count,
   output logic [31:0] output_word_count,
   output logic        error
);

   typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

   state_t      state_reg, state_next;
   logic [63:0] acc_reg, acc_next;
   logic [6:0]  fill_reg, fill_next;
   logic [31:0] bit_count_reg, bit_count_next;
   logic [31:0] word_count_reg, word_count_next;
   logic        error_reg, error_next;
   logic        out_valid_reg, out_valid_next;
   logic [31:0] out_word_reg, out_word_next;
   logic        out_end_reg, out_end_next;
   logic [31:0] out_bc_reg, out_bc_next;
   logic [31:0] out_wc_reg, out_wc_next;

   // A start (from IDLE or ACTIVE) rebases every accumulator to zero this cycle.
   logic        starting, block_open, append, too_long, emit;
   logic [5:0]  len;
   logic [63:0] mask64, placed;
   logic [31:0] masked;
   logic [63:0] acc_base, acc_a, acc_e;
   logic [6:0]  fill_base, fill_a, fill_e;
   logic [31:0] bc_base, bc_a, wc_base, wc_e;

   assign starting   = input_start && (state_reg != FLUSH);
   assign block_open = starting || (state_reg == ACTIVE);
   assign append     = block_open && input_valid;
   assign too_long   = append && (codeword_length > 32'd32);
   assign len        = !append ? 6'd0 : (too_long ? 6'd32 : codeword_length[5:0]);
   assign mask64     = (64'd1 << len) - 64'd1;
   assign masked     = sum & mask64[31:0];

   assign acc_base   = starting ? 64'd0 : acc_reg;
   assign fill_base  = starting ? 7'd0  : fill_reg;
   assign bc_base    = starting ? 32'd0 : bit_count_reg;
   assign wc_base    = starting ? 32'd0 : word_count_reg;

   // Left-justify the codeword at bit 63, then drop it just below the current fill.
   assign placed     = ({masked, 32'd0} << (7'd32 - {1'b0, len})) >> fill_base;
   assign acc_a      = acc_base | placed;
   assign fill_a     = fill_base + {1'b0, len};
   assign bc_a       = bc_base + {26'd0, len};
   assign emit       = block_open && (fill_a >= 7'd32);
   assign acc_e      = emit ? (acc_a << 32) : acc_a;
   assign fill_e     = emit ? (fill_a - 7'd32) : fill_a;
   assign wc_e       = emit ? (wc_base + 32'd1) : wc_base;

   always_comb begin
      state_next      = state_reg;
      acc_next        = acc_reg;
      fill_next       = fill_reg;
      bit_count_next  = bit_count_reg;
      word_count_next = word_count_reg;
      error_next      = error_reg;
      out_valid_next  = 1'b0;
      out_word_next   = 32'd0;
      out_end_next    = 1'b0;
      out_bc_next     = 32'd0;
      out_wc_next     = 32'd0;

      if (state_reg == FLUSH) begin
         out_valid_next = 1'b1;
         out_word_next  = acc_reg[63:32];
         out_end_next   = 1'b1;
         out_bc_next    = bit_count_reg;
         out_wc_next    = word_count_reg + 32'd1;
         state_next     = IDLE;
         acc_next       = 64'd0;
         fill_next      = 7'd0;
      end else if (block_open) begin
         if ((starting && state_reg == ACTIVE) || too_long)
            error_next = 1'b1;
         state_next      = ACTIVE;
         acc_next        = acc_e;
         fill_next       = fill_e;
         bit_count_next  = bc_a;
         word_count_next = wc_e;
         if (emit) begin
            out_valid_next = 1'b1;
            out_word_next  = acc_a[63:32];
         end
         if (input_end) begin
            if (emit && fill_e != 7'd0) begin
               state_next = FLUSH;
            end else begin
               state_next   = IDLE;
               acc_next     = 64'd0;
               fill_next    = 7'd0;
               out_end_next = 1'b1;
               out_bc_next  = bc_a;
               if (!emit && fill_a != 7'd0) begin
                  // Tail fits in one word; bits below the fill are already zero.
                  out_valid_next  = 1'b1;
                  out_word_next   = acc_a[63:32];
                  out_wc_next     = wc_base + 32'd1;
                  word_count_next = wc_base + 32'd1;
               end else begin
                  out_wc_next = wc_e;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         acc_reg        <= 64'd0;
         fill_reg       <= 7'd0;
         bit_count_reg  <= 32'd0;
         word_count_reg <= 32'd0;
         error_reg      <= 1'b0;
         out_valid_reg  <= 1'b0;
         out_word_reg   <= 32'd0;
         out_end_reg    <= 1'b0;
         out_bc_reg     <= 32'd0;
         out_wc_reg     <= 32'd0;
      end else begin
         state_reg      <= state_next;
         acc_reg        <= acc_next;
         fill_reg       <= fill_next;
         bit_count_reg  <= bit_count_next;
         word_count_reg <= word_count_next;
         error_reg      <= error_next;
         out_valid_reg  <= out_valid_next;
         out_word_reg   <= out_word_next;
         out_end_reg    <= out_end_next;
         out_bc_reg     <= out_bc_next;
         out_wc_reg     <= out_wc_next;
      end
   end

   assign output_valid      = out_valid_reg;
   assign output_word       = out_word_reg;
   assign output_end        = out_end_reg;
   assign output_bit_count  = out_bc_reg;
   assign output_word_count = out_wc_reg;
   assign error             = error_reg;

endmodule
